// File: rtl/half_pkg.sv
// half_pkg: shared FSM type and half-precision constants for the byte-to-half packer
package half_pkg;
  typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} pack_state_t;
  localparam int HALF_W = 16;
  localparam logic [15:0] HALF_ZERO = 16'h0000;
endpackage

// File: rtl/uint8_to_half.sv
// uint8_to_half: combinational unsigned byte to IEEE-754 binary16 conversion
module uint8_to_half
  import half_pkg::*;
(
  input  logic [7:0]        val,
  output logic [HALF_W-1:0] half
);
  logic [2:0] msb;
  logic [9:0] mant;
  // position of the highest set bit; later (higher) bits override earlier ones
  always_comb begin
    msb = 3'd0;
    for (int i = 0; i < 8; i++) msb = val[i] ? 3'(i) : msb;
  end
  assign mant = {2'b00, val} << (4'd10 - {1'b0, msb});
  assign half = (val == 8'd0) ? HALF_ZERO : {1'b0, 5'd15 + {2'b00, msb}, mant};
endmodule

// File: rtl/half_pack_ctrl.sv
// half_pack_ctrl: frames a byte stream, converts each byte to half and packs LANES halves per word
module half_pack_ctrl
  import half_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        frame_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HALF_W*LANES-1:0] out_data,
  output logic                    out_last
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(LANES - 1);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  pack_state_t state, nxt;
  logic [HALF_W-1:0] lane_q [LANES];
  logic [IW-1:0] lane_idx;
  logic [LEN_W-1:0] elem, len;
  logic [HALF_W-1:0] half;
  logic acc, last_elem, word_end;
  uint8_to_half u_cvt (.val(in_data), .half(half));
  assign in_ready  = state == RUN;
  assign out_valid = state == EMIT;
  assign done      = state == DONE;
  assign busy      = state != IDLE;
  assign acc       = in_valid & in_ready;
  assign last_elem = elem == len - ONE;
  assign word_end  = (lane_idx == LAST_LANE) || last_elem;
  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign out_data[HALF_W*g +: HALF_W] = lane_q[g];
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // next state: a zero-length frame goes straight to DONE, a full or final word goes to EMIT
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ((frame_len == '0) ? DONE : RUN) : IDLE;
      RUN:     nxt = (acc && word_end) ? EMIT : RUN;
      EMIT:    nxt = out_ready ? (out_last ? DONE : RUN) : EMIT;
      default: nxt = IDLE;
    endcase
  end
  // lanes and counters; lanes are zeroed after each emitted word so a short final word pads with 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= HALF_ZERO;
      lane_idx <= '0;
      elem     <= '0;
      len      <= '0;
      out_last <= 1'b0;
    end else if (state == IDLE && start) begin
      len      <= frame_len;
      elem     <= '0;
      lane_idx <= '0;
      out_last <= 1'b0;
    end else if (acc) begin
      lane_q[lane_idx] <= half;
      lane_idx <= lane_idx + 1'b1;
      elem     <= elem + ONE;
      out_last <= last_elem;
    end else if (out_valid && out_ready) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= HALF_ZERO;
      lane_idx <= '0;
      out_last <= 1'b0;
    end
  end
endmodule
